// File: rtl/msrr_burst_if.sv
// Handshake/data bundle for msrr_burst: op controls and parallel/serial data in,
// register contents and burst status out.
interface msrr_burst_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] pIn;
    logic             sIn;
    logic             start;
    logic [AW-1:0]    amt;
    logic [WIDTH-1:0] Q;
    logic             sOut;
    logic             busy;
    logic             done;

    modport master (
        output en, mode, pIn, sIn, start, amt,
        input  Q, sOut, busy, done
    );

    modport slave (
        input  en, mode, pIn, sIn, start, amt,
        output Q, sOut, busy, done
    );
endinterface

// File: rtl/msrr_burst.sv
// Multi-mode shift/rotate register with a burst engine that repeats one op
// a programmed number of times.
//
// state  | meaning
// IDLE   | direct single-cycle ops on en; start latches op/count
// BUSY   | applying latched op once per edge, counting down
// DONE   | one-cycle completion pulse, Q held
module msrr_burst #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input logic        clc,
    input logic        R,
    msrr_burst_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] q, q_nxt, sh_q;
    logic             sout, sout_nxt, sh_s;
    logic [AW-1:0]    cnt, cnt_nxt;
    logic [2:0]       op, op_nxt, op_sel;

    always_ff @(posedge clc or negedge R) begin
        if (!R) begin
            state <= S_IDLE;
            q     <= '0;
            sout  <= 1'b0;
            cnt   <= '0;
            op    <= 3'b000;
        end else begin
            state <= state_nxt;
            q     <= q_nxt;
            sout  <= sout_nxt;
            cnt   <= cnt_nxt;
            op    <= op_nxt;
        end
    end

    // One shared shifter: the latched op while bursting, the live mode otherwise.
    always_comb begin
        op_sel = (state == S_BUSY) ? op : bus.mode;
        sh_q   = q;
        sh_s   = sout;
        case (op_sel)
            3'b001: begin sh_q = {q[0], q[WIDTH-1:1]};       sh_s = q[0];       end
            3'b010: begin sh_q = {q[1:0], q[WIDTH-1:2]};     sh_s = q[1];       end
            3'b011: begin sh_q = {bus.sIn, q[WIDTH-1:1]};    sh_s = q[0];       end
            3'b100: begin sh_q = {q[WIDTH-2:0], bus.sIn};    sh_s = q[WIDTH-1]; end
            3'b101: begin sh_q = {q[WIDTH-2:0], q[WIDTH-1]}; sh_s = q[WIDTH-1]; end
            3'b110: begin sh_q = bus.pIn;                                       end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        q_nxt     = q;
        sout_nxt  = sout;
        cnt_nxt   = cnt;
        op_nxt    = op;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    op_nxt    = bus.mode;
                    cnt_nxt   = bus.amt;
                    state_nxt = (bus.amt != '0) ? S_BUSY : S_DONE;
                end else if (bus.en) begin
                    q_nxt    = sh_q;
                    sout_nxt = sh_s;
                end
            end
            S_BUSY: begin
                q_nxt    = sh_q;
                sout_nxt = sh_s;
                cnt_nxt  = cnt - AW'(1);
                if (cnt == AW'(1)) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign bus.Q    = q;
    assign bus.sOut = sout;
    assign bus.busy = (state == S_BUSY);
    assign bus.done = (state == S_DONE);

endmodule

// File: tb/tb_msrr_burst.sv
// Self-checking bench for msrr_burst (WIDTH=8): constant vector table, directed
// burst corner sequences, and random ops checked against an arithmetic model.
module tb_msrr_burst;

    logic clc = 1'b0;
    logic R   = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] mq;
    logic       ms;

    msrr_burst_if #(.WIDTH(8), .AW(4)) bus ();
    msrr_burst #(.WIDTH(8), .AW(4)) dut (.clc(clc), .R(R), .bus(bus));

    always #5 clc = ~clc;

    initial begin
        #500000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       en;
        logic [2:0] mode;
        logic       sin;
        logic [7:0] pin;
        logic [7:0] q;
        logic       so;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clc);
        #1;
    endtask

    function automatic logic [7:0] rotr(input logic [7:0] v, input int k);
        logic [15:0] d;
        d = {v, v} >> k;
        return d[7:0];
    endfunction

    // Result of applying op n times from (q, s): closed form from the op definitions.
    function automatic void model(input logic [2:0] op, input int n, input logic [7:0] q,
                                  input logic s, input logic sin, input logic [7:0] pin,
                                  output logic [7:0] nq, output logic ns);
        logic [7:0] m;
        nq = q;
        ns = s;
        if (n == 0) return;
        case (op)
            3'd1: begin nq = rotr(q, n % 8);       ns = q[(n - 1) % 8];     end
            3'd2: begin nq = rotr(q, (2 * n) % 8); ns = q[(2 * n - 1) % 8]; end
            3'd3: begin
                m  = (n >= 8) ? 8'hFF : ~(8'hFF >> n);
                nq = (n >= 8) ? 8'h00 : (q >> n);
                if (sin) nq = nq | m;
                ns = (n <= 8) ? q[n - 1] : sin;
            end
            3'd4: begin
                m  = (n >= 8) ? 8'hFF : ~(8'hFF << n);
                nq = (n >= 8) ? 8'h00 : (q << n);
                if (sin) nq = nq | m;
                ns = (n <= 8) ? q[8 - n] : sin;
            end
            3'd5: begin nq = rotr(q, (8 - n % 8) % 8); ns = q[(8 - n % 8) % 8]; end
            3'd6: nq = pin;
            default: ;
        endcase
    endfunction

    task automatic set_idle();
        bus.en = 1'b0; bus.mode = 3'd0; bus.start = 1'b0; bus.amt = 4'd0;
    endtask

    task automatic load(input logic [7:0] v);
        bus.en = 1'b1; bus.mode = 3'd6; bus.pIn = v; bus.start = 1'b0;
        step();
        bus.en = 1'b0;
        mq = v;
    endtask

    // Issues a burst and follows it to DONE, randomising every ignored input meanwhile.
    task automatic run_burst(input logic [2:0] m, input logic [3:0] n,
                             output int busy_cnt, output bit got_done);
        bus.start = 1'b1; bus.mode = m; bus.amt = n; bus.en = 1'($urandom);
        step();
        busy_cnt = 0;
        got_done = 1'b0;
        for (int c = 0; c < 40 && !got_done; c++) begin
            if (bus.busy && bus.done) chk("busy_done_excl", 1, 0);
            if (bus.busy) busy_cnt++;
            if (bus.done) got_done = 1'b1;
            else begin
                bus.start = 1'($urandom); bus.en = 1'($urandom);
                bus.mode = 3'($urandom); bus.amt = 4'($urandom);
                step();
            end
        end
        set_idle();
        step();
        chk("post_done_idle", {bus.busy, bus.done}, 2'b00);
    endtask

    initial begin
        int bc;
        bit gd;
        logic [7:0] eq;
        logic       es;

        vecs[0]  = '{1'b1, 3'd6, 1'b0, 8'hA5, 8'hA5, 1'b0};
        vecs[1]  = '{1'b1, 3'd1, 1'b0, 8'h00, 8'hD2, 1'b1};
        vecs[2]  = '{1'b1, 3'd6, 1'b0, 8'hA5, 8'hA5, 1'b1};
        vecs[3]  = '{1'b1, 3'd2, 1'b0, 8'h00, 8'h69, 1'b0};
        vecs[4]  = '{1'b0, 3'd1, 1'b0, 8'h00, 8'h69, 1'b0};
        vecs[5]  = '{1'b1, 3'd0, 1'b1, 8'hFF, 8'h69, 1'b0};
        vecs[6]  = '{1'b1, 3'd7, 1'b1, 8'hFF, 8'h69, 1'b0};
        vecs[7]  = '{1'b1, 3'd6, 1'b0, 8'h00, 8'h00, 1'b0};
        vecs[8]  = '{1'b1, 3'd3, 1'b1, 8'h00, 8'h80, 1'b0};
        vecs[9]  = '{1'b1, 3'd3, 1'b1, 8'h00, 8'hC0, 1'b0};
        vecs[10] = '{1'b1, 3'd3, 1'b1, 8'h00, 8'hE0, 1'b0};
        vecs[11] = '{1'b1, 3'd3, 1'b1, 8'h00, 8'hF0, 1'b0};
        vecs[12] = '{1'b1, 3'd4, 1'b0, 8'h00, 8'hE0, 1'b1};
        vecs[13] = '{1'b1, 3'd5, 1'b0, 8'h00, 8'hC1, 1'b1};
        vecs[14] = '{1'b1, 3'd4, 1'b1, 8'h00, 8'h83, 1'b1};

        set_idle();
        bus.pIn = 8'h00; bus.sIn = 1'b0;
        #1;
        chk("reset_q", bus.Q, 8'h00);
        chk("reset_sout", bus.sOut, 1'b0);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_done", bus.done, 1'b0);
        #10 R = 1'b1;
        #1;

        for (int i = 0; i < 15; i++) begin
            bus.en = vecs[i].en; bus.mode = vecs[i].mode;
            bus.sIn = vecs[i].sin; bus.pIn = vecs[i].pin; bus.start = 1'b0;
            step();
            chk($sformatf("vec%0d_q", i), bus.Q, vecs[i].q);
            chk($sformatf("vec%0d_sout", i), bus.sOut, vecs[i].so);
            chk($sformatf("vec%0d_stat", i), {bus.busy, bus.done}, 2'b00);
        end
        set_idle();

        // rotate-left burst of 3 with start/mode toggled while busy
        load(8'h81);
        bus.start = 1'b1; bus.mode = 3'd5; bus.amt = 4'd3;
        step();
        chk("b3_e0_q", bus.Q, 8'h81);
        chk("b3_e0_busy", {bus.busy, bus.done}, 2'b10);
        bus.start = 1'b1; bus.mode = 3'd6; bus.pIn = 8'h55; bus.en = 1'b1;
        step();
        chk("b3_e1_q", bus.Q, 8'h03);
        chk("b3_e1_busy", {bus.busy, bus.done}, 2'b10);
        bus.start = 1'b0; bus.mode = 3'd1;
        step();
        chk("b3_e2_q", bus.Q, 8'h06);
        chk("b3_e2_busy", {bus.busy, bus.done}, 2'b10);
        bus.start = 1'b1;
        step();
        chk("b3_e3_q", bus.Q, 8'h0C);
        chk("b3_e3_done", {bus.busy, bus.done}, 2'b01);
        set_idle();
        step();
        chk("b3_e4_q", bus.Q, 8'h0C);
        chk("b3_e4_idle", {bus.busy, bus.done}, 2'b00);

        // amt=0
        bus.start = 1'b1; bus.mode = 3'd1; bus.amt = 4'd0;
        step();
        chk("a0_q", bus.Q, 8'h0C);
        chk("a0_done", {bus.busy, bus.done}, 2'b01);
        set_idle();
        step();
        chk("a0_after", {bus.busy, bus.done}, 2'b00);

        // amt above WIDTH wraps
        load(8'h01);
        run_burst(3'd1, 4'd9, bc, gd);
        chk("a9_busy_cycles", bc, 9);
        chk("a9_done", gd, 1'b1);
        chk("a9_q", bus.Q, 8'h80);
        chk("a9_sout", bus.sOut, 1'b1);
        ms = bus.sOut === 1'b1 ? 1'b1 : 1'b1;

        // start beats en; latched load reloads pIn each step
        bus.start = 1'b1; bus.en = 1'b1; bus.mode = 3'd6; bus.pIn = 8'hFF; bus.amt = 4'd2;
        step();
        chk("pri_e0_q", bus.Q, 8'h80);
        chk("pri_e0_busy", bus.busy, 1'b1);
        bus.start = 1'b0; bus.en = 1'b0;
        step();
        chk("pri_e1_q", bus.Q, 8'hFF);
        step();
        chk("pri_e2_q", bus.Q, 8'hFF);
        chk("pri_e2_done", {bus.busy, bus.done}, 2'b01);
        set_idle();
        step();

        // async reset mid-burst
        load(8'hA5);
        bus.start = 1'b1; bus.mode = 3'd1; bus.amt = 4'd5;
        step();
        bus.start = 1'b0;
        step();
        #2 R = 1'b0;
        #1;
        chk("rst_mid_q", bus.Q, 8'h00);
        chk("rst_mid_stat", {bus.busy, bus.done}, 2'b00);
        chk("rst_mid_sout", bus.sOut, 1'b0);
        #3 R = 1'b1;
        #1;
        step();
        chk("rst_hold_q", bus.Q, 8'h00);
        load(8'h01);
        run_burst(3'd5, 4'd1, bc, gd);
        chk("rst_after_busy", bc, 1);
        chk("rst_after_q", bus.Q, 8'h02);
        mq = 8'h02;
        ms = 1'b0;

        // random direct ops and bursts against the model
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 2) != 0) begin
                bus.en = 1'($urandom); bus.mode = 3'($urandom);
                bus.sIn = 1'($urandom); bus.pIn = 8'($urandom); bus.start = 1'b0;
                model(bus.mode, bus.en ? 1 : 0, mq, ms, bus.sIn, bus.pIn, eq, es);
                step();
                chk($sformatf("rnd%0d_direct_q", it), bus.Q, eq);
                chk($sformatf("rnd%0d_direct_sout", it), bus.sOut, es);
                mq = eq; ms = es;
            end else begin
                logic [2:0] m;
                logic [3:0] n;
                m = 3'($urandom); n = 4'($urandom);
                bus.sIn = 1'($urandom); bus.pIn = 8'($urandom);
                model(m, int'(n), mq, ms, bus.sIn, bus.pIn, eq, es);
                run_burst(m, n, bc, gd);
                chk($sformatf("rnd%0d_burst_len", it), bc, int'(n));
                chk($sformatf("rnd%0d_burst_done", it), gd, 1'b1);
                chk($sformatf("rnd%0d_burst_q", it), bus.Q, eq);
                chk($sformatf("rnd%0d_burst_sout", it), bus.sOut, es);
                mq = eq; ms = es;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
